// File: rtl/rr_word_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rr_word_mux
//  Brief    : N-channel valid/ready word mux with fixed, round-robin and
//             forced arbitration feeding a single registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
module rr_word_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    localparam logic [1:0] c_MODE_RR     = 2'b01;
    localparam logic [1:0] c_MODE_FORCED = 2'b10;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]     ptr_q,       ptr_d;

    logic                 w_load;
    logic                 w_lo_any, w_hi_any, w_fc_any, w_gnt_any;
    logic [SEL_W-1:0]     w_lo_idx, w_hi_idx, w_gnt_idx;
    logic [CHANNELS-1:0]  w_grant;
    logic [WIDTH-1:0]     w_sel_data;

    assign w_load = !out_valid_q || out_ready;

    // Descending scan: the last hit is the lowest index. The "hi" search only
    // considers channels at or above the RR pointer; "lo" is the wrap fallback.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_fc_any = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = i[SEL_W-1:0];
                if (i[SEL_W-1:0] >= ptr_q) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = i[SEL_W-1:0];
                end
                if (sel == i[SEL_W-1:0]) begin
                    w_fc_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gnt_any = w_lo_any;
        w_gnt_idx = w_lo_idx;
        case (mode)
            c_MODE_RR: begin
                if (w_hi_any) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_hi_idx;
                end
            end
            c_MODE_FORCED: begin
                w_gnt_any = w_fc_any;
                w_gnt_idx = sel;
            end
            default: ;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_grant
            assign w_grant[g]  = w_gnt_any && (w_gnt_idx == SEL_W'(g));
            assign in_ready[g] = w_grant[g] && w_load && rst_n;
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (w_load) begin
            out_valid_d = w_gnt_any;
            if (w_gnt_any) begin
                out_data_d = w_sel_data;
                out_chan_d = w_gnt_idx;
                if (mode == c_MODE_RR) begin
                    ptr_d = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0
                                                                : w_gnt_idx + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_word_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rr_word_mux
//  Brief    : Scoreboard bench for rr_word_mux: directed arbitration vectors
//             plus a protocol-respecting random soak.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_word_mux;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 5;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [1:0]                mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    rr_word_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [SEL_W+WIDTH-1:0] sb_q[$];
    logic                   m_valid;
    int                     m_ptr;
    logic [CHANNELS-1:0]    m_xfer;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_xfer  = '0;
    endtask

    // Reference model: predicts grant/in_ready each cycle and queues the beat
    int                  p_gidx;
    logic                p_load;
    logic [CHANNELS-1:0] p_rdy;
    always @(negedge clk) begin
        if (rst_n) begin
            p_load = !m_valid || out_ready;
            p_gidx = -1;
            if (mode == 2'b01) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (p_gidx < 0 && in_valid[(m_ptr + k) % CHANNELS])
                        p_gidx = (m_ptr + k) % CHANNELS;
                end
            end else if (mode == 2'b10) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (sel == c && in_valid[c]) p_gidx = c;
                end
            end else begin
                for (int c = CHANNELS - 1; c >= 0; c--) begin
                    if (in_valid[c]) p_gidx = c;
                end
            end
            p_rdy = '0;
            if (p_gidx >= 0 && p_load) p_rdy[p_gidx] = 1'b1;
            chk("in_ready", 64'(in_ready), 64'(p_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            m_xfer = p_rdy;
            if (p_load) begin
                if (p_gidx >= 0) begin
                    sb_q.push_back({SEL_W'(p_gidx), in_data[p_gidx*WIDTH +: WIDTH]});
                    m_valid = 1'b1;
                    if (mode == 2'b01) m_ptr = (p_gidx + 1) % CHANNELS;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    logic [SEL_W+WIDTH-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual chan=%0d data=%0h required=none", out_chan, out_data);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_out_chan", 64'(out_chan), 64'(mon_exp[SEL_W+WIDTH-1:WIDTH]));
                chk("sb_out_data", 64'(out_data), 64'(mon_exp[WIDTH-1:0]));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        mode      = 2'b00;
        sel       = '0;
        out_ready = 1'b1;
        model_clear();
        #3;
        chk("rst_in_ready",  64'(in_ready),  64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_out_chan",  64'(out_chan),  64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed priority: channel 1 always beats channel 3
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("fp_out_chan",  64'(out_chan), 64'd1);
            chk("fp_out_data",  64'(out_data), 64'hBBBB0001);
            chk("fp_in_ready",  64'(in_ready), 64'b0010);
        end

        // Round-robin, all channels valid
        @(posedge clk);
        #1;
        in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid = 4'b1111;
        mode     = 2'b01;
        begin
            int exp_seq [5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk("rr_all_chan", 64'(out_chan), 64'(exp_seq[k]));
            end
        end

        // Round-robin, channels 0 and 3 only
        do_reset();
        in_valid = 4'b1001;
        begin
            int exp_seq [4] = '{0, 3, 0, 3};
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk("rr_1001_chan", 64'(out_chan), 64'(exp_seq[k]));
            end
        end

        // Backpressure with a channel-2 beat held
        do_reset();
        in_valid = 4'b0100;
        @(posedge clk);
        #1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_chan",  64'(out_chan),  64'd2);
            chk("bp_out_data",  64'(out_data),  64'hA2);
            chk("bp_in_ready",  64'(in_ready),  64'b0000);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'b1000);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_chan", 64'(out_chan), 64'd3);
        chk("bp_next_data", 64'(out_data), 64'hA3);

        // Forced select
        @(posedge clk);
        #1;
        mode     = 2'b10;
        sel      = 5'd2;
        in_valid = 4'b0100;
        @(negedge clk);
        chk("fs_sel2_ready", 64'(in_ready), 64'b0100);
        @(posedge clk);
        @(negedge clk);
        chk("fs_sel2_chan",  64'(out_chan),  64'd2);
        chk("fs_sel2_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 4'b0011;
        @(negedge clk);
        chk("fs_novalid_ready", 64'(in_ready), 64'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("fs_drained_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        sel      = 5'd5;
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fs_sel5_ready", 64'(in_ready),  64'b0000);
            chk("fs_sel5_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
        end

        // Asynchronous reset with a held beat
        #1;
        mode     = 2'b00;
        in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hDEADBEEF};
        in_valid = 4'b0001;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("ar_held_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'h0);
        chk("ar_out_data",  64'(out_data),  64'h0);
        chk("ar_out_chan",  64'(out_chan),  64'h0);
        chk("ar_in_ready",  64'(in_ready),  64'h0);
        #2;
        rst_n = 1'b1;

        // Random soak; a channel only changes after it has been accepted
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!in_valid[c] || m_xfer[c]) begin
                    in_valid[c]                = 1'($urandom_range(0, 1));
                    in_data[c*WIDTH +: WIDTH] = $urandom;
                end
            end
            mode      = 2'($urandom_range(0, 3));
            sel       = SEL_W'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
